// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory load/store path.
//   dmem_state_t      : responder FSM states
//   DMEM_ERR_*        : error cause bits returned by dmem_addr_err()
//   DATA_W_C/ADDR_W_C : data and byte-address widths for RV64 ld/sd
package riscv_mem_pkg;

  localparam int unsigned DATA_W_C = 64;
  localparam int unsigned ADDR_W_C = 64;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_WAIT,
    DM_RESP
  } dmem_state_t;

  localparam logic [1:0] DMEM_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] DMEM_ERR_RANGE    = 2'b10;

  // Error causes for a doubleword access; zero means the access is legal.
  // The word number is compared in full so high addresses never alias into the store.
  function automatic logic [1:0] dmem_addr_err(input logic [ADDR_W_C-1:0] addr,
                                               input int unsigned         words);
    logic [1:0] err;
    err = 2'b00;
    if (addr[2:0] != 3'b000) err = err | DMEM_ERR_MISALIGN;
    if ({3'b000, addr[ADDR_W_C-1:3]} >= 64'(words)) err = err | DMEM_ERR_RANGE;
    return err;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request/response bundle between the control unit (master) and the
// data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata           : store data
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata/rsp_err   : load data / error flag, qualified by rsp_valid
interface dmem_responder_if #(
  parameter int unsigned DATA_W = riscv_mem_pkg::DATA_W_C
);

  logic                                 req_valid;
  logic                                 req_ready;
  logic                                 req_we;
  logic [riscv_mem_pkg::ADDR_W_C-1:0]   req_addr;
  logic [DATA_W-1:0]                    req_wdata;
  logic                                 rsp_valid;
  logic [DATA_W-1:0]                    rsp_rdata;
  logic                                 rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Data store: WORDS x DATA_W, synchronous write, registered read. No reset.
//   i_clk   : clock
//   i_we    : write enable, i_wdata written to word i_idx
//   i_re    : read enable, word i_idx loaded into o_rdata register
//   i_idx   : word index
//   i_wdata : write data
//   o_rdata : read register output, holds until the next read
module dmem_array #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned WORDS  = 256,
  localparam int unsigned IDX_W  = $clog2(WORDS)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target of the multicycle ld/sd port. Accepts one request
// at a time, waits LATENCY cycles, then emits a single response beat.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : dmem_responder_if slave (request in, response out)
// WORDS must be a power of two >= 2; LATENCY is 1..15.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_C,
  parameter int unsigned WORDS   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  dmem_responder_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(WORDS);

  dmem_state_t       r_state;
  dmem_state_t       w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;

  logic              r_we;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;

  logic              r_rsp_load;
  logic              r_rsp_err;

  logic              w_req_ready;
  logic              w_rsp_valid;
  logic              w_accept;
  logic              w_live_err;
  logic              w_enter_resp;
  logic              w_cur_we;
  logic [IDX_W-1:0]  w_cur_idx;
  logic [DATA_W-1:0] w_cur_wdata;
  logic              w_cur_err;
  logic              w_arr_we;
  logic              w_arr_re;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_accept   = bus.req_valid & w_req_ready;
  assign w_live_err = |dmem_addr_err(bus.req_addr, WORDS);

  // With LATENCY=1 RESP is entered on the accept edge itself, so the array must
  // see the live request then; otherwise it sees the captured one.
  always_comb begin
    if (r_state == DM_IDLE) begin
      w_cur_we    = bus.req_we;
      w_cur_idx   = bus.req_addr[3 +: IDX_W];
      w_cur_wdata = bus.req_wdata;
      w_cur_err   = w_live_err;
    end else begin
      w_cur_we    = r_we;
      w_cur_idx   = r_idx;
      w_cur_wdata = r_wdata;
      w_cur_err   = r_err;
    end
  end

  assign w_enter_resp = (w_state_next == DM_RESP);
  assign w_arr_we     = w_enter_resp & w_cur_we & ~w_cur_err;
  assign w_arr_re     = w_enter_resp & ~w_cur_we & ~w_cur_err;

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= DM_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // FSM: next state and latency counter
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      DM_IDLE: begin
        if (w_accept) begin
          if (LATENCY > 1) begin
            w_state_next = DM_WAIT;
            w_cnt_next   = 4'(LATENCY - 1);
          end else begin
            w_state_next = DM_RESP;
          end
        end
      end
      DM_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = DM_RESP;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
        end
      end
      DM_RESP: w_state_next = DM_IDLE;
      default: w_state_next = DM_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_req_ready = (r_state == DM_IDLE);
    w_rsp_valid = (r_state == DM_RESP);
  end

  // Request capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= bus.req_we;
      r_idx   <= bus.req_addr[3 +: IDX_W];
      r_wdata <= bus.req_wdata;
      r_err   <= w_live_err;
    end
  end

  // Response qualifiers, updated only when RESP is entered so they hold afterwards
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_load <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_enter_resp) begin
      r_rsp_load <= ~w_cur_we & ~w_cur_err;
      r_rsp_err  <= w_cur_err;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_idx   (w_cur_idx),
    .i_wdata (w_cur_wdata),
    .o_rdata (w_arr_rdata)
  );

  // Array read register is not reset; gating keeps rdata at 0 after reset and for stores/errors.
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = r_rsp_load ? w_arr_rdata : '0;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one LATENCY=2 and one LATENCY=1 instance.
module tb_dmem_responder;

  localparam int unsigned LAT2 = 2;
  localparam int unsigned LAT1 = 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n2 = 1'b1;
  logic rst_n1 = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t q2[$];
  exp_t q1[$];
  exp_t e2;
  exp_t e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.DATA_W(64)) bus2 ();
  dmem_responder_if #(.DATA_W(64)) bus1 ();

  dmem_responder #(.DATA_W(64), .WORDS(256), .LATENCY(LAT2)) u_dut2 (
    .i_clk   (clk),
    .i_rst_n (rst_n2),
    .bus     (bus2)
  );

  dmem_responder #(.DATA_W(64), .WORDS(256), .LATENCY(LAT1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n1),
    .bus     (bus1)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Monitors: accept edge counted as edge c; rsp_valid seen at the negedge after edge
  // c+LATENCY-1, i.e. during clock cycle N+LATENCY when N ends at the accept edge.
  always @(negedge clk) begin
    if (bus2.rsp_valid === 1'b1) begin
      if (q2.size() == 0) fail_now("dut2 unexpected rsp_valid");
      else begin
        e2 = q2.pop_front();
        check64("dut2 rdata", bus2.rsp_rdata, e2.rdata);
        check64("dut2 err", {63'd0, bus2.rsp_err}, {63'd0, e2.err});
        check64("dut2 latency", 64'(cyc - e2.acc), 64'(LAT2 - 1));
        check64("dut2 ready low in RESP", {63'd0, bus2.req_ready}, 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.rsp_valid === 1'b1) begin
      if (q1.size() == 0) fail_now("dut1 unexpected rsp_valid");
      else begin
        e1 = q1.pop_front();
        check64("dut1 rdata", bus1.rsp_rdata, e1.rdata);
        check64("dut1 err", {63'd0, bus1.rsp_err}, {63'd0, e1.err});
        check64("dut1 latency", 64'(cyc - e1.acc), 64'(LAT1 - 1));
        check64("dut1 ready low in RESP", {63'd0, bus1.req_ready}, 64'd0);
      end
    end
  end

  // Drive a request (valid stays high afterwards) and push its expected response on accept.
  task automatic do_req(input int sel, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rd,
                        input logic exp_err, output int acc);
    bit   done;
    logic rdy;
    exp_t e;
    done = 0;
    acc  = -1;
    @(negedge clk);
    if (sel == 2) begin
      bus2.req_we = we; bus2.req_addr = addr; bus2.req_wdata = wdata; bus2.req_valid = 1'b1;
    end else begin
      bus1.req_we = we; bus1.req_addr = addr; bus1.req_wdata = wdata; bus1.req_valid = 1'b1;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      rdy = (sel == 2) ? bus2.req_ready : bus1.req_ready;
      if (rdy === 1'b1) begin
        @(posedge clk);
        #1;
        acc = cyc;
        e   = '{exp_rd, exp_err, acc};
        if (sel == 2) q2.push_back(e);
        else q1.push_back(e);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) fail_now("request accept timeout");
  endtask

  task automatic drain();
    @(negedge clk);
    bus2.req_valid = 1'b0;
    bus1.req_valid = 1'b0;
    for (int i = 0; i < 30 && (q2.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    check64("dut2 queue drained", 64'(q2.size()), 64'd0);
    check64("dut1 queue drained", 64'(q1.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input int sel);
    if (sel == 2) begin
      check64("dut2 reset ready", {63'd0, bus2.req_ready}, 64'd1);
      check64("dut2 reset valid", {63'd0, bus2.rsp_valid}, 64'd0);
      check64("dut2 reset err", {63'd0, bus2.rsp_err}, 64'd0);
      check64("dut2 reset rdata", bus2.rsp_rdata, 64'd0);
    end else begin
      check64("dut1 reset ready", {63'd0, bus1.req_ready}, 64'd1);
      check64("dut1 reset valid", {63'd0, bus1.rsp_valid}, 64'd0);
      check64("dut1 reset err", {63'd0, bus1.rsp_err}, 64'd0);
      check64("dut1 reset rdata", bus1.rsp_rdata, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, a2;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;

    // Initial reset
    #3;
    rst_n2 = 1'b0;
    rst_n1 = 1'b0;
    #1;
    check_reset_outputs(2);
    check_reset_outputs(1);
    repeat (2) @(negedge clk);
    rst_n2 = 1'b1;
    rst_n1 = 1'b1;
    @(negedge clk);
    check64("dut2 ready after release", {63'd0, bus2.req_ready}, 64'd1);

    // Store then load
    do_req(2, 1'b1, 64'h0, 64'h1111_2222_3333_4444, 64'h0, 1'b0, a0);
    do_req(2, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, a0);
    do_req(2, 1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, a0);
    drain();
    check64("dut2 rdata holds after RESP", bus2.rsp_rdata, 64'hDEADBEEF_CAFEF00D);

    // Errors and the top-word boundary
    do_req(2, 1'b0, 64'h13, 64'h0, 64'h0, 1'b1, a0);
    do_req(2, 1'b0, 64'h8000_0000_0000_0000, 64'h0, 64'h0, 1'b1, a0);
    do_req(2, 1'b1, 64'h7F8, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, a0);
    do_req(2, 1'b0, 64'h7F8, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, a0);
    do_req(2, 1'b1, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, a0);
    drain();
    check64("dut2 err holds after RESP", {63'd0, bus2.rsp_err}, 64'd1);

    // Asynchronous reset mid-cycle clears outputs at once; store survives
    @(negedge clk);
    #2;
    rst_n2 = 1'b0;
    #1;
    check_reset_outputs(2);
    @(negedge clk);
    rst_n2 = 1'b1;
    // Word 0 untouched by the out-of-range store that would alias to index 0
    do_req(2, 1'b0, 64'h0, 64'h0, 64'h1111_2222_3333_4444, 1'b0, a0);
    do_req(2, 1'b1, 64'h20, 64'h5555, 64'h0, 1'b0, a0);
    do_req(2, 1'b0, 64'h20, 64'h0, 64'h5555, 1'b0, a0);
    drain();

    // Back-to-back with valid held high
    do_req(2, 1'b0, 64'h0, 64'h0, 64'h1111_2222_3333_4444, 1'b0, a0);
    do_req(2, 1'b0, 64'h10, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, a1);
    do_req(2, 1'b0, 64'h20, 64'h0, 64'h5555, 1'b0, a2);
    check64("dut2 spacing 1-2", 64'(a1 - a0), 64'(LAT2 + 1));
    check64("dut2 spacing 2-3", 64'(a2 - a1), 64'(LAT2 + 1));
    drain();

    // Reset while a store is in WAIT: no response, write dropped
    do_req(2, 1'b1, 64'h20, 64'h1, 64'h0, 1'b0, a0);
    rst_n2 = 1'b0;
    bus2.req_valid = 1'b0;
    q2.delete();
    #1;
    check_reset_outputs(2);
    repeat (3) @(negedge clk);
    rst_n2 = 1'b1;
    do_req(2, 1'b0, 64'h20, 64'h0, 64'h5555, 1'b0, a0);
    drain();

    // LATENCY=1 instance
    do_req(1, 1'b1, 64'h8, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0, 1'b0, a0);
    do_req(1, 1'b0, 64'h8, 64'h0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, a0);
    do_req(1, 1'b0, 64'h9, 64'h0, 64'h0, 1'b1, a0);
    drain();
    do_req(1, 1'b0, 64'h8, 64'h0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, a0);
    do_req(1, 1'b0, 64'h8, 64'h0, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, a1);
    check64("dut1 spacing", 64'(a1 - a0), 64'(LAT1 + 1));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
